// File: rtl/div_sequencer.sv
// div_sequencer: RV32M divide-unit controller around an unsigned radix-16
// divider core. Accepts DIV/DIVU/REM/REMU, hands unsigned magnitudes to the
// core, resolves special cases and one-entry cache hits locally, and returns
// the sign-corrected result.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            kill the in-flight or pending request (no response)
//   req_valid/ready  request handshake; req_op 0=DIV 1=DIVU 2=REM 3=REMU
//   req_a, req_b     dividend (rs1), divisor (rs2)
//   resp_valid/ready response handshake; resp_data quotient or remainder
//   core_en          start pulse to the core
//   core_dividend/divisor  unsigned magnitudes, held through LAUNCH
//   core_ready       core idle
//   core_q, core_r   core results, valid only while core_vout is high
//   core_vout        one-cycle completion pulse
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             core_en,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_q,
  input  logic [WIDTH-1:0] core_r,
  input  logic             core_vout
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN} state_t;
  state_t state;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Captured request
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_signed, op_rem;
  // Raw core results
  logic [WIDTH-1:0] raw_q, raw_r;
  // One-entry result cache
  logic             cache_valid, cache_signed;
  logic [WIDTH-1:0] cache_a, cache_b, cache_q, cache_r;

  // Accept-time decode
  logic             req_signed, req_rem, special, hit;
  logic [WIDTH-1:0] a_mag, b_mag, sp_q, sp_r, fast_data;
  // Sign-corrected core results
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    req_signed = ~req_op[0];
    req_rem    = req_op[1];
    a_mag      = (req_signed && req_a[WIDTH-1]) ? -req_a : req_a;
    b_mag      = (req_signed && req_b[WIDTH-1]) ? -req_b : req_b;
    special    = 1'b1;
    sp_q       = '0;
    sp_r       = '0;
    if (req_b == '0) begin
      sp_q = '1;
      sp_r = req_a;
    end else if (req_signed && req_a == MIN_VAL && req_b == '1) begin
      sp_q = MIN_VAL;
    end else if (a_mag == '0) begin
      // zero dividend must never reach the core's leading-one detector
      sp_q = '0;
    end else begin
      special = 1'b0;
    end
    hit = cache_valid && (req_a == cache_a) && (req_b == cache_b) &&
          (req_signed == cache_signed) && !special;
    if (special)
      fast_data = req_rem ? sp_r : sp_q;
    else
      fast_data = req_rem ? cache_r : cache_q;
  end

  always_comb begin
    q_fix = (op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -raw_q : raw_q;
    r_fix = (op_signed && a_reg[WIDTH-1]) ? -raw_r : raw_r;
  end

  // Decoded from state so the start pulse can never fire against a busy core
  // or in the same cycle a flush retires the request.
  assign req_ready = (state == IDLE) && !flush;
  assign core_en   = (state == LAUNCH) && core_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      core_dividend <= '0;
      core_divisor  <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_signed     <= 1'b0;
      op_rem        <= 1'b0;
      raw_q         <= '0;
      raw_r         <= '0;
      cache_valid   <= 1'b0;
      cache_signed  <= 1'b0;
      cache_a       <= '0;
      cache_b       <= '0;
      cache_q       <= '0;
      cache_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && req_valid) begin
            a_reg         <= req_a;
            b_reg         <= req_b;
            op_signed     <= req_signed;
            op_rem        <= req_rem;
            core_dividend <= a_mag;
            core_divisor  <= b_mag;
            if (special || hit) begin
              resp_data  <= fast_data;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (flush)           state <= IDLE;
          else if (core_ready) state <= WAIT;
        end
        WAIT: begin
          // the core keeps shifting after core_vout, so grab results now
          if (core_vout) begin
            raw_q <= core_q;
            raw_r <= core_r;
            state <= flush ? IDLE : FIX;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cache_valid  <= 1'b1;
            cache_signed <= op_signed;
            cache_a      <= a_reg;
            cache_b      <= b_reg;
            cache_q      <= q_fix;
            cache_r      <= r_fix;
            resp_data    <= op_rem ? r_fix : q_fix;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (core_vout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer with a behavioural radix-16 core model whose run
// length depends on the dividend's significant nibbles.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        core_en;
  logic [31:0] core_dividend, core_divisor;
  logic        core_ready;
  logic [31:0] core_q, core_r;
  logic        core_vout;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .core_en(core_en), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_ready(core_ready), .core_q(core_q), .core_r(core_r), .core_vout(core_vout)
  );

  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic        busy = 1'b0;
  logic        stall = 1'b0;
  int          cnt = 0;
  logic [31:0] mq = '0, mr = '0;
  int          en_count = 0;
  int          en_bad = 0;

  function automatic int run_len(logic [31:0] v);
    int bl = 0;
    for (int i = 0; i < 32; i++) if (v[i]) bl = i + 1;
    return (bl + 3) / 4 + 1;
  endfunction

  assign core_ready = !busy && !stall;
  assign core_vout  = busy && (cnt == 1);
  // outside the completion cycle the outputs are deliberately scrambled
  assign core_q = core_vout ? mq : ~mq;
  assign core_r = core_vout ? mr : (mr ^ 32'hA5A5_5A5A);

  always @(posedge clk) begin
    if (core_en) en_count <= en_count + 1;
    if (core_en && !core_ready) en_bad <= en_bad + 1;
    if (reset) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (core_en && !busy) begin
      busy <= 1'b1;
      cnt  <= run_len(core_dividend);
      mq   <= core_dividend / core_divisor;
      mr   <= core_dividend % core_divisor;
    end else if (busy) begin
      if (cnt == 1) busy <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, return response data, latency from accept and the
  // number of core_en pulses seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] data, output int lat, output int ens);
    int c;
    int e0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    c = 0;
    while (!req_ready && c < 50) begin @(negedge clk); c++; end
    e0 = en_count;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    data = resp_data;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    ens = en_count - e0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          ens;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] d;
  int          lat, ens, c, bad;

  initial begin
    // op: 0=DIV 1=DIVU 2=REM 3=REMU; normal latency = 3 + run length
    vecs[0]  = '{"divu_100_7",    2'd1, 32'd100,       32'd7,         32'd14,        6,  1};
    vecs[1]  = '{"remu_100_7_hit",2'd3, 32'd100,       32'd7,         32'd2,         1,  0};
    vecs[2]  = '{"div_m7_2",      2'd0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  5,  1};
    vecs[3]  = '{"rem_m7_2_hit",  2'd2, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1,  0};
    vecs[4]  = '{"divu_5_0",      2'd1, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  0};
    vecs[5]  = '{"rem_5_0",       2'd2, 32'd5,         32'd0,         32'd5,         1,  0};
    vecs[6]  = '{"div_ovf",       2'd0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  0};
    vecs[7]  = '{"rem_ovf",       2'd2, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1,  0};
    vecs[8]  = '{"divu_0_3",      2'd1, 32'd0,         32'd3,         32'd0,         1,  0};
    vecs[9]  = '{"divu_m7_2_miss",2'd1, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  12, 1};
    vecs[10] = '{"rem_min_7",     2'd2, 32'h80000000,  32'd7,         32'hFFFFFFFE,  12, 1};
    vecs[11] = '{"div_7_m2",      2'd0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  5,  1};
    vecs[12] = '{"rem_7_m2_hit",  2'd2, 32'd7,         32'hFFFFFFFE,  32'd1,         1,  0};
    vecs[13] = '{"divu_ovf_pat",  2'd1, 32'h80000000,  32'hFFFFFFFF,  32'd0,         12, 1};
    vecs[14] = '{"div_0_0",       2'd0, 32'd0,         32'd0,         32'hFFFFFFFF,  1,  0};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data",  resp_data,           32'd0);
    check("rst_core_en",    {31'd0, core_en},    32'd0);
    check("rst_dividend",   core_dividend,       32'd0);
    check("rst_divisor",    core_divisor,        32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, d, lat, ens);
      check({vecs[i].name, "_data"}, d, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_core_en"}, ens, vecs[i].ens);
    end

    // core busy for the first LAUNCH cycles: start is held back two cycles
    stall = 1'b1;
    fork
      begin repeat (4) @(negedge clk); stall = 1'b0; end
    join_none
    issue(2'd1, 32'd200, 32'd7, d, lat, ens);
    check("stall_data", d, 32'd28);
    check("stall_lat", lat, 32'd8);
    check("stall_core_en", ens, 32'd1);

    // flush two cycles after core_en, then drain until core_vout
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'hFFFFFFFF; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    check("flush_core_en", {31'd0, core_en}, 32'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    c = 0;
    while (!core_vout && c < 40) begin
      if (resp_valid || req_ready) bad = 1;
      @(negedge clk);
      c++;
    end
    check("drain_cycles", c, 32'd6);
    check("drain_quiet", bad, 32'd0);
    @(negedge clk);
    check("drain_idle_ready", {31'd0, req_ready}, 32'd1);
    check("drain_no_resp", {31'd0, resp_valid}, 32'd0);
    issue(2'd1, 32'd9, 32'd3, d, lat, ens);
    check("post_flush_data", d, 32'd3);
    check("post_flush_lat", lat, 32'd5);
    issue(2'd1, 32'hFFFFFFFF, 32'd3, d, lat, ens);
    check("flushed_miss_data", d, 32'h55555555);
    check("flushed_miss_core_en", ens, 32'd1);
    check("flushed_miss_lat", lat, 32'd12);

    // response back-pressure
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd50; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    c = 0;
    while (!resp_valid && c < 50) begin @(negedge clk); c++; end
    check("bp_lat", c + 1, 32'd6);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!resp_valid || resp_data !== 32'd10 || req_ready) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 32'd0);
    check("bp_data", resp_data, 32'd10);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_single_accept", {31'd0, resp_valid}, 32'd0);
    check("bp_back_idle", {31'd0, req_ready}, 32'd1);

    // reset while waiting on the core
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'h12345678; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("wrst_req_ready",  {31'd0, req_ready},  32'd1);
    check("wrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("wrst_resp_data",  resp_data,           32'd0);
    check("wrst_core_en",    {31'd0, core_en},    32'd0);
    check("wrst_dividend",   core_dividend,       32'd0);
    check("wrst_divisor",    core_divisor,        32'd0);
    reset = 1'b0;
    issue(2'd1, 32'hFFFFFFFF, 32'd3, d, lat, ens);
    check("cache_cleared_core_en", ens, 32'd1);
    check("cache_cleared_data", d, 32'h55555555);
    issue(2'd0, 32'h80000000, 32'd2, d, lat, ens);
    check("div_min_2_data", d, 32'hC0000000);
    check("div_min_2_lat", lat, 32'd12);

    check("core_en_only_when_ready", en_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Control wrapper that turns the unsigned radix-16 divider core into the RV32M divide unit. It accepts DIV/DIVU/REM/REMU requests from the execute stage over a valid/ready handshake. Requests go to the core as unsigned magnitudes, special cases are resolved without the core, and the signed result is returned over a second valid/ready handshake. It also holds a one-entry result cache, so a DIV/REM pair on the same operands costs one core run.

## Interface
Parameters:
- WIDTH, 32, operand/result width; multiple of 4.

Ports:
- Clock and reset: clk and reset; reset is synchronous, active-high.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  kill the in-flight or pending request; no response is produced for it.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  0 = DIV, 1 = DIVU, 2 = REM, 3 = REMU.
- req_a  in  WIDTH  dividend (rs1).
- req_b  in  WIDTH  divisor (rs2).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result this cycle.
- resp_data  out  WIDTH  quotient or remainder, as selected by the op.
- core_en  out  1  start pulse to the core.
- core_dividend  out  WIDTH  unsigned dividend magnitude.
- core_divisor  out  WIDTH  unsigned divisor magnitude.
- core_ready  in  1  core idle.
- core_q  in  WIDTH  core quotient; valid only in the core_vout cycle.
- core_r  in  WIDTH  core remainder; valid only in the core_vout cycle.
- core_vout  in  1  one-cycle completion pulse from the core.

## Operation
Signedness: signed = (op == DIV or op == REM).

Magnitudes:
- |a| = signed & a[MSB] ? -a : a; |b| likewise.
- Negating the minimum value gives 2^(WIDTH-1) unsigned, which is correct.
- core_dividend and core_divisor are registered at accept and held stable through LAUNCH.

Special cases are checked in priority order at accept and never launch the core:
1. b == 0: q = all ones, r = a.
2. signed, a == 0x80..0, b == all ones: q = 0x80..0, r = 0.
3. |a| == 0: q = 0, r = 0. This case is mandatory because the core's leading-one detector is undefined for a zero dividend.

Cache hit: cache_valid, the stored a, b and signedness all match, and no special case applies. The stored signed q/r are returned.

Sign correction on a core result:
- q is negated iff signed & (a[MSB] ^ b[MSB]).
- r is negated iff signed & a[MSB].

Cache update:
- On every normal completion, store a, b, signedness and both corrected results, and set cache_valid.
- cache_valid is cleared only by reset.

FSM states:
- IDLE: req_ready = 1. On req_valid, accept and go to RESP for a special case or cache hit, otherwise go to LAUNCH.
- LAUNCH: assert core_en when core_ready = 1, then go to WAIT. If core_ready = 0, hold in LAUNCH.
- WAIT: on core_vout, capture core_q and core_r (the core keeps shifting its registers afterwards), then go to FIX.
- FIX: apply sign correction, update the cache, go to RESP.
- RESP: resp_valid = 1 with resp_data held stable. On resp_ready go to IDLE.
- DRAIN: entered on flush during LAUNCH-after-core_en or WAIT. Wait for core_vout, discard the result, go to IDLE. The cache is not updated.

Flush:
- In IDLE, LAUNCH before core_en, FIX or RESP: go straight to IDLE.
- flush has priority over req_valid and resp_ready in the same cycle.
- req_ready = 0 while flush = 1.

## Timing
Reset values:
- state = IDLE.
- req_ready = 1, resp_valid = 0, resp_data = 0.
- core_en = 0, core_dividend = 0, core_divisor = 0.
- cache_valid = 0.

Handshakes:
- A request transfers on req_valid & req_ready.
- A response transfers on resp_valid & resp_ready.
- Only one request is outstanding; req_ready = 0 in every state except IDLE.

Latency, measured from the accept edge:
- Special case or cache hit: resp_valid high the next cycle (latency 1).
- Normal case: LAUNCH, then the core run, then FIX, then RESP. Latency is 3 + N, where N is the core_en-to-core_vout distance (dividend-width dependent, at most WIDTH/4 + 1 cycles).

Other rules:
- core_en is a single-cycle pulse and is never asserted unless core_ready = 1.
- resp_data is unchanged while resp_valid = 1 and resp_ready = 0.
- Reset in any state returns to the reset values within one cycle. The core is reset by the same signal.

## Test plan
- DIVU 100 / 7 → resp_data 14; REMU 100 / 7 → 2; normal-path latency measured at 3 + N.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; REM issued immediately after the DIV is a cache hit, latency 1, no core_en.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0; DIVU 0 / 3 → 0. None of these assert core_en.
- flush two cycles after core_en on DIVU 0xFFFFFFFF / 3 → no resp_valid, DRAIN until core_vout. A following DIVU 9 / 3 returns 3, the cache still misses for the flushed operands.
- resp_ready held low for 5 cycles on DIVU 50 / 5 → resp_valid stays high with data 10, req_ready stays 0; a single accept when resp_ready rises.
- reset asserted in WAIT → next cycle all outputs at their reset values; a subsequent DIV 0x80000000 / 2 → 0xC0000000.
